// File: rtl/pc_stack_param.sv
// Parametrised PC stack: DEPTH levels of NIBBLES x 4-bit program counters with a wrapping pointer.
// Optional sticky overflow/underflow flags are enabled by defining PC_STACK_FLAGS_EN.
module pc_stack_param #(
  parameter int NIBBLES = 3,
  parameter int DEPTH   = 4,
  localparam int ADDR_W = 4 * NIBBLES,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              halt,
  input  logic [2:0]        cycle,
  input  logic [1:0]        op,
  input  logic              inc,
  input  logic [NIBBLES-1:0] load_en,
  input  logic [3:0]        load_data,
  output logic [3:0]        pc_word,
  output logic              pc_enable,
  output logic [ADDR_W-1:0] pc_active,
  output logic [PTR_W-1:0]  sp
`ifdef PC_STACK_FLAGS_EN
  ,
  output logic              ovf,
  output logic              unf,
  input  logic              flags_clr
`endif
);

  localparam logic [1:0]       OP_PUSH = 2'b01;
  localparam logic [1:0]       OP_POP  = 2'b10;
  localparam logic [PTR_W-1:0] SP_TOP  = PTR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] levels [DEPTH];
  logic [PTR_W-1:0]  sp_q;
  logic [PTR_W-1:0]  sp_next;
  logic [ADDR_W-1:0] base_pc;
  logic [ADDR_W-1:0] active_next;
  logic [31:0]       pc_pad;

  // A push carries the caller PC into the new level; a pop exposes the stored level untouched.
  always_comb begin
    sp_next = sp_q;
    case (op)
      OP_PUSH: sp_next = sp_q + 1'b1;
      OP_POP:  sp_next = sp_q - 1'b1;
      default: sp_next = sp_q;
    endcase
    base_pc = (op == OP_PUSH) ? levels[sp_q] : levels[sp_next];
    active_next = base_pc;
    if (load_en != '0) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (load_en[i]) active_next[4*i +: 4] = load_data;
      end
    end else if (inc) begin
      active_next = base_pc + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) levels[i] <= '0;
    end else if (!halt) begin
      sp_q <= sp_next;
      levels[sp_next] <= active_next;
    end
  end

  assign pc_active = levels[sp_q];
  assign sp        = sp_q;

  // Padding to 32 bits keeps the nibble select in range for every cycle value.
  assign pc_pad = 32'(pc_active);

  always_comb begin
    pc_enable = 1'b0;
    pc_word   = 4'h0;
    if (int'(cycle) < NIBBLES) begin
      pc_enable = 1'b1;
      pc_word   = pc_pad[{cycle, 2'b00} +: 4];
    end
  end

`ifdef PC_STACK_FLAGS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!halt) begin
      if (flags_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (op == OP_PUSH && sp_q == SP_TOP) ovf <= 1'b1;
        if (op == OP_POP && sp_q == '0) unf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_stack_param.sv
// Directed bench for pc_stack_param (NIBBLES=3, DEPTH=4); define PC_STACK_FLAGS_EN to cover the flags.
module tb_pc_stack_param;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt;
  logic [2:0]  cycle;
  logic [1:0]  op;
  logic        inc;
  logic [2:0]  load_en;
  logic [3:0]  load_data;
  logic [3:0]  pc_word;
  logic        pc_enable;
  logic [11:0] pc_active;
  logic [1:0]  sp;
`ifdef PC_STACK_FLAGS_EN
  logic        ovf;
  logic        unf;
  logic        flags_clr;
`endif

  int tests = 0;
  int fails = 0;

  pc_stack_param #(.NIBBLES(3), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .halt(halt),
    .cycle(cycle),
    .op(op),
    .inc(inc),
    .load_en(load_en),
    .load_data(load_data),
    .pc_word(pc_word),
    .pc_enable(pc_enable),
    .pc_active(pc_active),
    .sp(sp)
`ifdef PC_STACK_FLAGS_EN
    ,
    .ovf(ovf),
    .unf(unf),
    .flags_clr(flags_clr)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock edge with the given controls, then return to idle and sample 1 ns after the edge.
  task automatic step(input logic [1:0] o, input logic i, input logic [2:0] le, input logic [3:0] d);
    op = o; inc = i; load_en = le; load_data = d;
    @(posedge clock);
    #1;
    op = 2'b00; inc = 1'b0; load_en = 3'b000; load_data = 4'h0;
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; cycle = 3'd7;
    op = 2'b00; inc = 1'b0; load_en = 3'b000; load_data = 4'h0;
`ifdef PC_STACK_FLAGS_EN
    flags_clr = 1'b0;
`endif
    #2;
    check("reset_pc", 32'(pc_active), 32'h0);
    check("reset_sp", 32'(sp), 32'h0);
`ifdef PC_STACK_FLAGS_EN
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_unf", 32'(unf), 32'h0);
`endif
    #1 reset = 1'b1;

    // Count up to 5, then walk the bus phases.
    for (int k = 0; k < 5; k++) step(2'b00, 1'b1, 3'b000, 4'h0);
    check("inc5_pc", 32'(pc_active), 32'h005);
    for (int c = 0; c < 8; c++) begin
      cycle = 3'(c);
      #1;
      check($sformatf("sweep_word_c%0d", c), 32'(pc_word), (c == 0) ? 32'h5 : 32'h0);
      check($sformatf("sweep_en_c%0d", c), 32'(pc_enable), (c < 3) ? 32'h1 : 32'h0);
    end
    cycle = 3'd7;

    // Carry and wrap.
    step(2'b00, 1'b0, 3'b111, 4'hF);
    check("load_fff", 32'(pc_active), 32'hFFF);
    step(2'b00, 1'b1, 3'b000, 4'h0);
    check("wrap_pc", 32'(pc_active), 32'h000);
    check("wrap_sp", 32'(sp), 32'h0);
    step(2'b00, 1'b1, 3'b001, 4'hA);
    check("load_beats_inc", 32'(pc_active), 32'h00A);

    // Call and return.
    step(2'b00, 1'b0, 3'b001, 4'h3);
    step(2'b00, 1'b0, 3'b010, 4'h2);
    step(2'b00, 1'b0, 3'b100, 4'h1);
    check("pc_123", 32'(pc_active), 32'h123);
    step(2'b01, 1'b0, 3'b111, 4'h4);
    check("call_sp", 32'(sp), 32'h1);
    check("call_pc", 32'(pc_active), 32'h444);
    step(2'b10, 1'b0, 3'b000, 4'h0);
    check("ret_sp", 32'(sp), 32'h0);
    check("ret_pc", 32'(pc_active), 32'h123);
`ifdef PC_STACK_FLAGS_EN
    check("ret_unf", 32'(unf), 32'h0);
`endif

    // Push with increment four times: levels 1..3 get 124..126, level 0 overwritten with 127.
    step(2'b01, 1'b1, 3'b000, 4'h0);
    check("push1_pc", 32'(pc_active), 32'h124);
    step(2'b01, 1'b1, 3'b000, 4'h0);
    step(2'b01, 1'b1, 3'b000, 4'h0);
    check("push3_sp", 32'(sp), 32'h3);
`ifdef PC_STACK_FLAGS_EN
    check("push3_ovf", 32'(ovf), 32'h0);
`endif
    step(2'b01, 1'b1, 3'b000, 4'h0);
    check("ovf_sp", 32'(sp), 32'h0);
    check("ovf_pc", 32'(pc_active), 32'h127);
`ifdef PC_STACK_FLAGS_EN
    check("ovf_flag", 32'(ovf), 32'h1);
`endif
    step(2'b10, 1'b0, 3'b000, 4'h0);
    check("unf_sp", 32'(sp), 32'h3);
    check("unf_pc", 32'(pc_active), 32'h126);
`ifdef PC_STACK_FLAGS_EN
    check("unf_flag", 32'(unf), 32'h1);
    check("unf_ovf_sticky", 32'(ovf), 32'h1);
    flags_clr = 1'b1;
    step(2'b00, 1'b0, 3'b000, 4'h0);
    flags_clr = 1'b0;
    check("clr_ovf", 32'(ovf), 32'h0);
    check("clr_unf", 32'(unf), 32'h0);
`endif

    // Halt freezes state while the bus keeps following cycle.
    halt = 1'b1;
    for (int k = 0; k < 3; k++) step(2'b01, 1'b1, 3'b111, 4'h9);
    check("halt_sp", 32'(sp), 32'h3);
    check("halt_pc", 32'(pc_active), 32'h126);
`ifdef PC_STACK_FLAGS_EN
    check("halt_ovf", 32'(ovf), 32'h0);
`endif
    cycle = 3'd0; #1;
    check("halt_word_c0", 32'(pc_word), 32'h6);
    cycle = 3'd1; #1;
    check("halt_word_c1", 32'(pc_word), 32'h2);
    cycle = 3'd2; #1;
    check("halt_word_c2", 32'(pc_word), 32'h1);
    check("halt_en_c2", 32'(pc_enable), 32'h1);
    cycle = 3'd7;
    halt = 1'b0;

    // Reach sp=2, pc=7A3, then reset asynchronously between edges.
    step(2'b10, 1'b0, 3'b000, 4'h0);
    step(2'b00, 1'b0, 3'b001, 4'h3);
    step(2'b00, 1'b0, 3'b010, 4'hA);
    step(2'b00, 1'b0, 3'b100, 4'h7);
    check("pre_rst_sp", 32'(sp), 32'h2);
    check("pre_rst_pc", 32'(pc_active), 32'h7A3);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sp", 32'(sp), 32'h0);
    check("async_rst_pc", 32'(pc_active), 32'h0);
    #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 1'b0, 3'b000, 4'h0);
      check($sformatf("post_rst_pop%0d_pc", k), 32'(pc_active), 32'h0);
    end
    check("post_rst_sp", 32'(sp), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
